// File: rtl/mod_classifier_if.sv
// Bundle of the classifier's judge-stage inputs and result outputs.
//   slave  : used by mod_classifier (inputs en/flags/measurements, drives results)
//   master : used by whoever feeds the judge values and consumes the results
// Signals:
//   en                      run enable
//   A_const .. Freq_square  discriminator flags from the judge stage
//   A_max .. Freq_edge_interv  signed judge-stage measurements (IO_width)
//   meas_trig               one-cycle measurement start pulse
//   mod_type                class code
//   mod_param               class parameter
//   am_pp                   signed envelope peak-to-peak (IO_width+1)
//   locked, result_valid    lock status and one-cycle result strobe
interface mod_classifier_if #(
  parameter int IO_width = 14
);
  logic                       en;
  logic                       A_const;
  logic                       A_square;
  logic                       Freq_const;
  logic                       Freq_square;
  logic signed [IO_width-1:0] A_max;
  logic signed [IO_width-1:0] A_min;
  logic signed [IO_width-1:0] A_freq;
  logic signed [IO_width-1:0] F_freq;
  logic signed [IO_width-1:0] A_edge_interv;
  logic signed [IO_width-1:0] Freq_edge_interv;
  logic                       meas_trig;
  logic [2:0]                 mod_type;
  logic [IO_width-1:0]        mod_param;
  logic signed [IO_width:0]   am_pp;
  logic                       locked;
  logic                       result_valid;

  modport slave (
    input  en, A_const, A_square, Freq_const, Freq_square,
    input  A_max, A_min, A_freq, F_freq, A_edge_interv, Freq_edge_interv,
    output meas_trig, mod_type, mod_param, am_pp, locked, result_valid
  );

  modport master (
    output en, A_const, A_square, Freq_const, Freq_square,
    output A_max, A_min, A_freq, F_freq, A_edge_interv, Freq_edge_interv,
    input  meas_trig, mod_type, mod_param, am_pp, locked, result_valid
  );
endinterface

// File: rtl/mod_classifier.sv
// Modulation classifier: repeatedly triggers a judge-stage measurement, waits
// for it to settle, latches the judge flags/measurements, classifies and only
// publishes a result once the same class has been seen STABLE_NUM rounds in a row.
// Ports:
//   clk  system clock (1.8 MHz sample rate)
//   rst  asynchronous active-high reset
//   bus  mod_classifier_if.slave (judge inputs in, results out)
//
// state  | meaning
// IDLE   | waiting for en
// TRIG   | one-cycle meas_trig pulse to the judge stage
// WAIT   | settle time, MEAS_WAIT cycles
// LATCH  | capture flags and measurements
// DECIDE | classify, update stability count, publish if stable
module mod_classifier #(
  parameter int          IO_width   = 14,
  parameter logic [31:0] MEAS_WAIT  = 32'd36000,
  parameter int          STABLE_NUM = 3
) (
  input logic            clk,
  input logic            rst,
  mod_classifier_if.slave bus
);

  localparam int              SW       = $clog2(STABLE_NUM + 1);
  localparam logic [SW-1:0]   STAB_MAX = SW'(STABLE_NUM);
  localparam logic [2:0]      C_CW     = 3'd0;
  localparam logic [2:0]      C_AM     = 3'd1;
  localparam logic [2:0]      C_FM     = 3'd2;
  localparam logic [2:0]      C_ASK    = 3'd3;
  localparam logic [2:0]      C_FSK    = 3'd4;
  localparam logic [2:0]      C_PSK    = 3'd5;
  localparam logic [2:0]      C_UNK    = 3'd7;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, LATCH, DECIDE} state_t;

  state_t                     r_state;
  logic [31:0]                r_wait_cnt;
  logic                       r_a_const, r_a_square, r_f_const, r_f_square;
  logic signed [IO_width-1:0] r_a_max, r_a_min, r_a_freq, r_f_freq;
  logic signed [IO_width-1:0] r_a_ei, r_f_ei;
  logic [2:0]                 r_prev_cls;
  logic [SW-1:0]              r_stab_cnt;
  logic                       r_meas_trig;
  logic [2:0]                 r_mod_type;
  logic [IO_width-1:0]        r_mod_param;
  logic signed [IO_width:0]   r_am_pp;
  logic                       r_locked;
  logic                       r_result_valid;

  logic [2:0]                 w_cls;
  logic [IO_width-1:0]        w_param;
  logic signed [IO_width:0]   w_am_pp;
  logic [SW-1:0]              w_stab_next;

  // First-match priority over the latched flags.
  always_comb begin
    w_cls = C_UNK;
    if (r_a_const && r_f_const)        w_cls = C_CW;
    else if (r_a_square && r_f_square) w_cls = C_PSK;
    else if (r_a_square)               w_cls = C_ASK;
    else if (r_f_square)               w_cls = C_FSK;
    else if (r_f_const)                w_cls = C_AM;
    else if (r_a_const)                w_cls = C_FM;
  end

  always_comb begin
    w_param = '0;
    case (w_cls)
      C_AM:         w_param = r_a_freq;
      C_FM:         w_param = r_f_freq;
      C_ASK, C_PSK: w_param = r_a_ei;
      C_FSK:        w_param = r_f_ei;
      default:      w_param = '0;
    endcase
  end

  // One extra bit after sign extension: full-range difference never wraps.
  assign w_am_pp = {r_a_max[IO_width-1], r_a_max} - {r_a_min[IO_width-1], r_a_min};

  always_comb begin
    w_stab_next = SW'(1);
    if (w_cls == r_prev_cls)
      w_stab_next = (r_stab_cnt >= STAB_MAX) ? STAB_MAX : r_stab_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_wait_cnt     <= '0;
      r_a_const      <= 1'b0;
      r_a_square     <= 1'b0;
      r_f_const      <= 1'b0;
      r_f_square     <= 1'b0;
      r_a_max        <= '0;
      r_a_min        <= '0;
      r_a_freq       <= '0;
      r_f_freq       <= '0;
      r_a_ei         <= '0;
      r_f_ei         <= '0;
      r_prev_cls     <= C_UNK;
      r_stab_cnt     <= '0;
      r_meas_trig    <= 1'b0;
      r_mod_type     <= C_UNK;
      r_mod_param    <= '0;
      r_am_pp        <= '0;
      r_locked       <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state     <= TRIG;
            r_meas_trig <= 1'b1;
          end
        end
        TRIG: begin
          r_meas_trig <= 1'b0;
          r_wait_cnt  <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          if (r_wait_cnt == MEAS_WAIT - 32'd1) r_state <= LATCH;
          else                                 r_wait_cnt <= r_wait_cnt + 32'd1;
        end
        LATCH: begin
          r_a_const  <= bus.A_const;
          r_a_square <= bus.A_square;
          r_f_const  <= bus.Freq_const;
          r_f_square <= bus.Freq_square;
          r_a_max    <= bus.A_max;
          r_a_min    <= bus.A_min;
          r_a_freq   <= bus.A_freq;
          r_f_freq   <= bus.F_freq;
          r_a_ei     <= bus.A_edge_interv;
          r_f_ei     <= bus.Freq_edge_interv;
          r_state    <= DECIDE;
        end
        DECIDE: begin
          r_stab_cnt <= w_stab_next;
          r_prev_cls <= w_cls;
          if (w_stab_next >= STAB_MAX) begin
            r_mod_type     <= w_cls;
            r_mod_param    <= w_param;
            r_am_pp        <= w_am_pp;
            r_locked       <= 1'b1;
            r_result_valid <= 1'b1;
          end else begin
            r_locked <= 1'b0;
          end
          if (bus.en) begin
            r_state     <= TRIG;
            r_meas_trig <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.meas_trig    = r_meas_trig;
  assign bus.mod_type     = r_mod_type;
  assign bus.mod_param    = r_mod_param;
  assign bus.am_pp        = r_am_pp;
  assign bus.locked       = r_locked;
  assign bus.result_valid = r_result_valid;

endmodule

// File: doc/mod_classifier.md
MOD_CLASSIFIER -- requirements
Module: mod_classifier

Interface
REQ-001 SHALL have parameters: IO_width, 14, data width; MEAS_WAIT, 32'd36000, settle cycles per round (20 ms at 1.8 MHz); STABLE_NUM, 3, consecutive agreeing rounds needed to lock.
REQ-002 SHALL have one clock; reset is asynchronous and active-high: clk  in  1  system clock (1.8 MHz sample rate); rst  in  1  async active-high reset.
REQ-003 SHALL have inputs: en  in  1  run enable; A_const, A_square, Freq_const, Freq_square  in  1 each  discriminator flags from the judge stage.
REQ-004 SHALL have inputs: A_max, A_min, A_freq, F_freq, A_edge_interv, Freq_edge_interv  in  IO_width each, signed  judge-stage measurements.
REQ-005 SHALL have outputs: meas_trig  out  1  measurement start pulse to the judge stage; mod_type  out  3  class code; mod_param  out  IO_width  class parameter; am_pp  out  IO_width+1  signed envelope peak-to-peak; locked  out  1; result_valid  out  1.

Function
REQ-006 SHALL use FSM states IDLE, TRIG, WAIT, LATCH, DECIDE.
REQ-007 IDLE: go to TRIG when en=1, else stay.
REQ-008 TRIG: lasts exactly one cycle; SHALL drive meas_trig=1 only in this state; then go to WAIT.
REQ-009 WAIT: 32-bit counter from 0 to MEAS_WAIT-1; leave to LATCH on the cycle the counter equals MEAS_WAIT-1; counter cleared on entry.
REQ-010 LATCH: register all flag and measurement inputs in one cycle; then go to DECIDE.
REQ-011 DECIDE: classify from latched values with the first-match priority in REQ-012; then go to TRIG if en=1, else IDLE.
REQ-012 Classification SHALL be: CW=0 (A_const & Freq_const); PSK=5 (A_square & Freq_square); ASK=3 (A_square & ~Freq_square); FSK=4 (Freq_square & ~A_square); AM=1 (~A_const & Freq_const); FM=2 (A_const & ~Freq_const); otherwise UNKNOWN=7.
REQ-013 Parameter selection SHALL be: AM->A_freq; FM->F_freq; ASK/PSK->A_edge_interv; FSK->Freq_edge_interv; CW/UNKNOWN->0.
REQ-014 am_pp SHALL equal A_max-A_min computed at IO_width+1 bits from sign-extended operands; it cannot overflow.
REQ-015 Stability counter SHALL work as follows: if the class equals the previous round's class, increment, saturating at STABLE_NUM; otherwise load 1 and store the new class as previous.
REQ-016 When the stability counter is >=STABLE_NUM after update in DECIDE: mod_type, mod_param, and am_pp SHALL update; locked=1; result_valid SHALL pulse for that one cycle.
REQ-017 When the stability counter is <STABLE_NUM after update: locked=0; mod_type, mod_param, and am_pp SHALL hold their last values; no result_valid.
REQ-018 A locked result SHALL appear 1 cycle after DECIDE; the round period is MEAS_WAIT+3 cycles; the first lock occurs at the end of round STABLE_NUM.
REQ-019 en deasserted outside IDLE SHALL NOT abort the round; the round completes through DECIDE, then goes to IDLE; outputs and stability state are kept.
REQ-020 Input changes during WAIT, TRIG, or DECIDE SHALL be ignored; only LATCH samples inputs.
REQ-021 UNKNOWN SHALL be a lockable class like any other.

Reset
REQ-022 While rst=1: state=IDLE; counters=0; meas_trig=0; mod_type=7; mod_param=0; am_pp=0; locked=0; result_valid=0; previous class=7; stability count=0.
REQ-023 rst asserted mid-round SHALL return the block to IDLE immediately with the REQ-022 values; the first TRIG follows deassertion at the first clk edge with en=1.

Verification (MEAS_WAIT=16, STABLE_NUM=3)
REQ-024 Scenario: en=1 continuously -> meas_trig single-cycle pulses exactly 19 cycles apart; no pulse while en=0.
REQ-025 Scenario: A_const=0, Freq_const=1, squares=0, A_freq=500, A_max=3000, A_min=-1000 for 3 rounds -> after round 3 DECIDE: mod_type=1, mod_param=500, am_pp=4000, locked=1, one result_valid pulse; none in rounds 1-2.
REQ-026 Scenario: locked AM, then A_square=1, Freq_square=1, A_edge_interv=60 -> next round locked=0 with outputs held at AM/500; after 3 PSK rounds mod_type=5, mod_param=60.
REQ-027 Scenario: Freq_square=1, A_square=0, A_const=1 but flags toggled only during WAIT cycles 2-10 and stable at LATCH -> classification uses LATCH values only (FSK=4, mod_param=Freq_edge_interv).
REQ-028 Scenario: A_max=8191, A_min=-8192 -> am_pp=16383 with no wrap.
REQ-029 Scenario: rst pulsed during WAIT of round 2 while locked -> all outputs return to REQ-022 values at once; after release, lock needs 3 new rounds.
